// File: rtl/trap_pkg.sv
// Shared types and constants for the trap/pipeline control unit.
// Includes the control-register map and the layout of the exception save stack.
package trap_pkg;

   typedef enum logic [1:0] {
      NOP  = 2'd0,
      EXRT = 2'd1,
      WRCR = 2'd2
   } ctrl_op_t;

   localparam logic [4:0] CR_STATUS     = 5'd0;
   localparam logic [4:0] CR_PRE_STATUS = 5'd1;
   localparam logic [4:0] CR_PC         = 5'd2;
   localparam logic [4:0] CR_EPC        = 5'd3;
   localparam logic [4:0] CR_EXP_VECTOR = 5'd4;
   localparam logic [4:0] CR_CAUSE      = 5'd5;
   localparam logic [4:0] CR_INT_MASK   = 5'd6;
   localparam logic [4:0] CR_IRQ        = 5'd7;
   localparam logic [4:0] CR_STK_LVL    = 5'd8;
   localparam logic [4:0] CR_CPU_INFO   = 5'd9;

   // The saved PC field matches the default ADDR_W word-address width.
   localparam int STK_PC_W = 30;

   typedef struct packed {
      logic [STK_PC_W-1:0] epc;
      logic                mode;
      logic                ie;
      logic                dly;
      logic [2:0]          code;
   } stk_entry_t;

   localparam logic [31:0] CPU_INFO = 32'h5452_0002;

endpackage

// File: rtl/trap_prio_enc.sv
// Lowest-index-wins priority encoder for the pending, unmasked IRQ vector.
// Also reports whether any request is pending at all.
module trap_prio_enc #(
   parameter int IRQ_W = 8,
   parameter int ID_W  = (IRQ_W > 1) ? $clog2(IRQ_W) : 1
) (
   input  logic [IRQ_W-1:0] i_req,
   output logic [ID_W-1:0]  o_id,
   output logic             o_any
);

   always_comb begin
      o_id = '0;
      // Walk downwards so the lowest set bit is the last one assigned.
      for (int i = IRQ_W - 1; i >= 0; i--) begin
         if (i_req[i]) o_id = ID_W'(i);
      end
      o_any = |i_req;
   end

endmodule

// File: rtl/trap_ctrl.sv
// Pipeline stall/flush generation, control-register file, nested exception
// save stack, vectored exception entry and prioritised IRQ detection.
module trap_ctrl
   import trap_pkg::*;
#(
   parameter int IRQ_W     = 8,
   parameter int STK_DEPTH = 4,
   parameter int ADDR_W    = 30,
   parameter int DATA_W    = 32,
   parameter int VEC_SHIFT = 2,
   localparam int ID_W     = (IRQ_W > 1) ? $clog2(IRQ_W) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        creg_rd_addr,
   output logic [DATA_W-1:0] creg_rd_data,
   output logic              exe_mode,
   input  logic [IRQ_W-1:0]  irq,
   output logic              int_detect,
   output logic [ID_W-1:0]   int_id,
   input  logic [ADDR_W-1:0] id_pc,
   input  logic [ADDR_W-1:0] mem_pc,
   input  logic              mem_en,
   input  logic              mem_br_flag,
   input  logic [1:0]        mem_ctrl_op,
   input  logic [4:0]        mem_dst_addr,
   input  logic [2:0]        mem_exp_code,
   input  logic [DATA_W-1:0] mem_data_in,
   input  logic              if_busy,
   input  logic              mem_busy,
   input  logic              ld_hazard,
   output logic [3:0]        stall,
   output logic [3:0]        flush,
   output logic [ADDR_W-1:0] new_pc
);

   localparam int SI_W  = $clog2(STK_DEPTH);
   localparam int LVL_W = SI_W + 1;

   logic              r_exe_mode;
   logic              r_int_en;
   logic [IRQ_W-1:0]  r_mask;
   logic [ADDR_W-1:0] r_exp_vector;
   logic [LVL_W-1:0]  r_lvl;
   logic              r_ovf;
   logic              r_unf;
   logic [ADDR_W-1:0] r_pre_pc;
   logic              r_br_q;
   stk_entry_t        r_stk [STK_DEPTH];

   logic              w_busy;
   logic              w_commit;
   logic              w_exc;
   logic              w_exrt;
   logic              w_wrcr;
   logic              w_redir;
   logic              w_lvl_zero;
   logic              w_full;
   logic [SI_W-1:0]   w_top_idx;
   logic [SI_W-1:0]   w_push_idx;
   stk_entry_t        w_top;
   logic              w_any_irq;

   assign w_busy     = if_busy | mem_busy;
   assign w_commit   = mem_en & ~w_busy;
   assign w_exc      = mem_en & (mem_exp_code != 3'd0);
   assign w_exrt     = mem_en & ~w_exc & (ctrl_op_t'(mem_ctrl_op) == EXRT);
   assign w_wrcr     = mem_en & ~w_exc & (ctrl_op_t'(mem_ctrl_op) == WRCR);
   assign w_redir    = w_exc | w_exrt | w_wrcr;
   assign w_lvl_zero = (r_lvl == '0);
   assign w_full     = (r_lvl == LVL_W'(STK_DEPTH));

   // With an empty stack the "top" is slot 0 for reads, writes and EXRT.
   assign w_top_idx  = w_lvl_zero ? '0 : SI_W'(r_lvl - LVL_W'(1));
   assign w_push_idx = w_full ? SI_W'(STK_DEPTH - 1) : r_lvl[SI_W-1:0];
   assign w_top      = r_stk[w_top_idx];

   assign stall = {w_busy, w_busy, w_busy, w_busy | ld_hazard};
   assign flush = {w_redir, w_redir, w_redir | ld_hazard, w_redir};

   always_comb begin
      new_pc = '0;
      if (w_exc)
         new_pc = r_exp_vector + (ADDR_W'(mem_exp_code) << VEC_SHIFT);
      else if (w_exrt)
         new_pc = w_top.epc;
      else if (w_wrcr)
         new_pc = mem_pc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_exe_mode   <= 1'b0;
         r_int_en     <= 1'b0;
         r_mask       <= '1;
         r_exp_vector <= '0;
         r_lvl        <= '0;
         r_ovf        <= 1'b0;
         r_unf        <= 1'b0;
         r_pre_pc     <= '0;
         r_br_q       <= 1'b0;
         for (int i = 0; i < STK_DEPTH; i++) r_stk[i] <= '0;
      end else if (w_commit) begin
         r_pre_pc <= mem_pc;
         r_br_q   <= mem_br_flag;
         if (w_exc) begin
            r_stk[w_push_idx] <= '{epc: r_pre_pc, mode: r_exe_mode, ie: r_int_en,
                                   dly: r_br_q, code: mem_exp_code};
            if (w_full) r_ovf <= 1'b1;
            else        r_lvl <= r_lvl + LVL_W'(1);
            r_exe_mode <= 1'b0;
            r_int_en   <= 1'b0;
         end else if (w_exrt) begin
            if (w_lvl_zero) begin
               r_unf <= 1'b1;
            end else begin
               r_exe_mode <= w_top.mode;
               r_int_en   <= w_top.ie;
               r_lvl      <= r_lvl - LVL_W'(1);
            end
         end else if (w_wrcr) begin
            case (mem_dst_addr)
               CR_STATUS: {r_int_en, r_exe_mode} <= mem_data_in[1:0];
               CR_PRE_STATUS: begin
                  r_stk[w_top_idx].ie   <= mem_data_in[1];
                  r_stk[w_top_idx].mode <= mem_data_in[0];
               end
               CR_EPC: r_stk[w_top_idx].epc <= mem_data_in[DATA_W-1:2];
               CR_CAUSE: begin
                  r_stk[w_top_idx].dly  <= mem_data_in[5];
                  r_stk[w_top_idx].code <= mem_data_in[2:0];
                  if (!mem_data_in[4]) r_ovf <= 1'b0;
                  if (!mem_data_in[3]) r_unf <= 1'b0;
               end
               CR_EXP_VECTOR: r_exp_vector <= mem_data_in[DATA_W-1:2];
               CR_INT_MASK:   r_mask       <= mem_data_in[IRQ_W-1:0];
               default: ;
            endcase
         end
      end
   end

   // CAUSE layout: [5] dly, [4] ovf, [3] unf, [2:0] exception code.
   always_comb begin
      creg_rd_data = '0;
      case (creg_rd_addr)
         CR_STATUS:     creg_rd_data[1:0] = {r_int_en, r_exe_mode};
         CR_PRE_STATUS: creg_rd_data[1:0] = {w_top.ie, w_top.mode};
         CR_PC:         creg_rd_data = {id_pc, 2'b00};
         CR_EPC:        creg_rd_data = {w_top.epc, 2'b00};
         CR_EXP_VECTOR: creg_rd_data = {r_exp_vector, 2'b00};
         CR_CAUSE:      creg_rd_data[5:0] = {w_top.dly, r_ovf, r_unf, w_top.code};
         CR_INT_MASK:   creg_rd_data = DATA_W'(r_mask);
         CR_IRQ:        creg_rd_data = DATA_W'(irq);
         CR_STK_LVL:    creg_rd_data = DATA_W'(r_lvl);
         CR_CPU_INFO:   creg_rd_data = DATA_W'(CPU_INFO);
         default:       creg_rd_data = '0;
      endcase
   end

   trap_prio_enc #(
      .IRQ_W (IRQ_W),
      .ID_W  (ID_W)
   ) u_prio_enc (
      .i_req (irq & ~r_mask),
      .o_id  (int_id),
      .o_any (w_any_irq)
   );

   assign int_detect = r_int_en & w_any_irq;
   assign exe_mode   = r_exe_mode;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl: reset state, vectored entry,
// nested stack overflow/underflow, IRQ priority, busy gating and hazards.
module tb_trap_ctrl;
   import trap_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  creg_rd_addr;
   logic [31:0] creg_rd_data;
   logic        exe_mode;
   logic [7:0]  irq;
   logic        int_detect;
   logic [2:0]  int_id;
   logic [29:0] id_pc;
   logic [29:0] mem_pc;
   logic        mem_en;
   logic        mem_br_flag;
   logic [1:0]  mem_ctrl_op;
   logic [4:0]  mem_dst_addr;
   logic [2:0]  mem_exp_code;
   logic [31:0] mem_data_in;
   logic        if_busy;
   logic        mem_busy;
   logic        ld_hazard;
   logic [3:0]  stall;
   logic [3:0]  flush;
   logic [29:0] new_pc;

   int n_pass  = 0;
   int n_total = 0;

   trap_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .creg_rd_addr (creg_rd_addr),
      .creg_rd_data (creg_rd_data),
      .exe_mode     (exe_mode),
      .irq          (irq),
      .int_detect   (int_detect),
      .int_id       (int_id),
      .id_pc        (id_pc),
      .mem_pc       (mem_pc),
      .mem_en       (mem_en),
      .mem_br_flag  (mem_br_flag),
      .mem_ctrl_op  (mem_ctrl_op),
      .mem_dst_addr (mem_dst_addr),
      .mem_exp_code (mem_exp_code),
      .mem_data_in  (mem_data_in),
      .if_busy      (if_busy),
      .mem_busy     (mem_busy),
      .ld_hazard    (ld_hazard),
      .stall        (stall),
      .flush        (flush),
      .new_pc       (new_pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic rd_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
      @(negedge clk);
      creg_rd_addr = addr;
      #1;
      chk(tag, creg_rd_data, exp);
   endtask

   task automatic idle();
      mem_en       = 1'b0;
      mem_br_flag  = 1'b0;
      mem_ctrl_op  = 2'(NOP);
      mem_dst_addr = 5'd0;
      mem_exp_code = 3'd0;
      mem_data_in  = 32'd0;
      mem_pc       = 30'd0;
      if_busy      = 1'b0;
      mem_busy     = 1'b0;
      ld_hazard    = 1'b0;
   endtask

   task automatic present(input logic [1:0] op, input logic [4:0] dst, input logic [2:0] code,
                          input logic [31:0] data, input logic [29:0] pc);
      mem_en       = 1'b1;
      mem_ctrl_op  = op;
      mem_dst_addr = dst;
      mem_exp_code = code;
      mem_data_in  = data;
      mem_pc       = pc;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      $display("txn op=%0d dst=%0d code=%0d pc=0x%0h busy=%0d -> new_pc=0x%0h flush=%b",
               mem_ctrl_op, mem_dst_addr, mem_exp_code, mem_pc, if_busy | mem_busy, new_pc, flush);
      idle();
   endtask

   task automatic wr(input logic [4:0] dst, input logic [31:0] data, input logic [29:0] pc);
      present(2'(WRCR), dst, 3'd0, data, pc);
      tick();
   endtask

   task automatic exc(input logic [2:0] code, input logic [29:0] pc);
      present(2'(NOP), 5'd0, code, 32'd0, pc);
      tick();
   endtask

   task automatic exrt();
      present(2'(EXRT), 5'd0, 3'd0, 32'd0, 30'd0);
      tick();
   endtask

   initial begin
      rst = 1'b1;
      irq = 8'h00;
      id_pc = 30'h123;
      creg_rd_addr = 5'd0;
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state
      #1;
      chk("rst_exe_mode", {31'd0, exe_mode}, 32'd0);
      chk("rst_stall", {28'd0, stall}, 32'd0);
      chk("rst_flush", {28'd0, flush}, 32'd0);
      chk("rst_new_pc", {2'd0, new_pc}, 32'd0);
      rd_chk("rst_status", CR_STATUS, 32'd0);
      rd_chk("rst_mask", CR_INT_MASK, 32'hFF);
      rd_chk("rst_lvl", CR_STK_LVL, 32'd0);
      rd_chk("rst_cause", CR_CAUSE, 32'd0);
      irq = 8'hFF;
      #1;
      chk("rst_int_detect", {31'd0, int_detect}, 32'd0);
      chk("rst_int_id", {29'd0, int_id}, 32'd0);
      irq = 8'h00;
      rd_chk("pc_read", CR_PC, 32'h48C);
      rd_chk("cpu_info", CR_CPU_INFO, 32'h5452_0002);
      rd_chk("unmapped_read", 5'd15, 32'd0);

      // Vectored entry: exp_vector word 0x100, pre_pc 0x40
      present(2'(WRCR), CR_EXP_VECTOR, 3'd0, 32'h400, 30'h40);
      chk("wrcr_flush", {28'd0, flush}, 32'hF);
      chk("wrcr_new_pc", {2'd0, new_pc}, 32'h40);
      tick();
      rd_chk("exp_vector", CR_EXP_VECTOR, 32'h400);
      present(2'(NOP), 5'd0, 3'd3, 32'd0, 30'h50);
      chk("exc3_new_pc", {2'd0, new_pc}, 32'h10C);
      chk("exc3_flush", {28'd0, flush}, 32'hF);
      tick();
      rd_chk("exc3_lvl", CR_STK_LVL, 32'd1);
      rd_chk("exc3_epc", CR_EPC, 32'h100);
      rd_chk("exc3_cause", CR_CAUSE, 32'h3);

      // Nest to overflow with distinct saved {int_en, mode}
      wr(CR_STATUS, 32'h3, 30'h60);
      exc(3'd1, 30'h61);
      rd_chk("nest_status_cleared", CR_STATUS, 32'd0);
      wr(CR_STATUS, 32'h1, 30'h70);
      exc(3'd2, 30'h71);
      wr(CR_STATUS, 32'h2, 30'h74);
      exc(3'd4, 30'h75);
      rd_chk("nest_lvl4", CR_STK_LVL, 32'd4);
      wr(CR_STATUS, 32'h3, 30'h77);
      exc(3'd5, 30'h78);
      rd_chk("ovf_lvl", CR_STK_LVL, 32'd4);
      rd_chk("ovf_cause", CR_CAUSE, 32'h15);
      rd_chk("ovf_epc", CR_EPC, 32'h1DC);
      rd_chk("ovf_pre_status", CR_PRE_STATUS, 32'h3);

      // LIFO unwinding
      present(2'(EXRT), 5'd0, 3'd0, 32'd0, 30'd0);
      chk("exrt1_new_pc", {2'd0, new_pc}, 32'h77);
      tick();
      chk("exrt1_exe_mode", {31'd0, exe_mode}, 32'd1);
      rd_chk("exrt1_status", CR_STATUS, 32'h3);
      exrt();
      rd_chk("exrt2_status", CR_STATUS, 32'h1);
      exrt();
      rd_chk("exrt3_status", CR_STATUS, 32'h3);
      exrt();
      rd_chk("exrt4_status", CR_STATUS, 32'h0);
      rd_chk("exrt4_lvl", CR_STK_LVL, 32'd0);
      exrt();
      rd_chk("unf_lvl", CR_STK_LVL, 32'd0);
      rd_chk("unf_cause", CR_CAUSE, 32'h1B);
      wr(CR_CAUSE, 32'h0, 30'h80);
      rd_chk("cause_cleared", CR_CAUSE, 32'h0);

      // Interrupts
      wr(CR_INT_MASK, 32'hF0, 30'h81);
      irq = 8'h28;
      present(2'(WRCR), CR_STATUS, 3'd0, 32'h2, 30'h82);
      chk("irq_before_commit", {31'd0, int_detect}, 32'd0);
      tick();
      #1;
      chk("irq_detect", {31'd0, int_detect}, 32'd1);
      chk("irq_id_lowmask", {29'd0, int_id}, 32'd3);
      rd_chk("irq_read", CR_IRQ, 32'h28);
      wr(CR_INT_MASK, 32'h08, 30'h83);
      #1;
      chk("irq_id_5", {29'd0, int_id}, 32'd5);
      wr(CR_INT_MASK, 32'hFF, 30'h84);
      #1;
      chk("irq_masked_detect", {31'd0, int_detect}, 32'd0);
      chk("irq_masked_id", {29'd0, int_id}, 32'd0);
      irq = 8'h00;
      wr(CR_STATUS, 32'h0, 30'h85);

      // Busy holds commit; redirect is still immediate
      mem_busy = 1'b1;
      mem_br_flag = 1'b1;
      present(2'(NOP), 5'd0, 3'd2, 32'd0, 30'h90);
      chk("busy_new_pc", {2'd0, new_pc}, 32'h108);
      chk("busy_stall", {28'd0, stall}, 32'hF);
      chk("busy_flush", {28'd0, flush}, 32'hF);
      rd_chk("busy_lvl_a", CR_STK_LVL, 32'd0);
      rd_chk("busy_lvl_b", CR_STK_LVL, 32'd0);
      mem_busy = 1'b0;
      tick();
      rd_chk("busy_release_lvl", CR_STK_LVL, 32'd1);

      // Exception beats EXRT in the same cycle
      present(2'(EXRT), 5'd0, 3'd1, 32'd0, 30'h95);
      chk("exc_vs_exrt_new_pc", {2'd0, new_pc}, 32'h104);
      tick();
      rd_chk("exc_vs_exrt_lvl", CR_STK_LVL, 32'd2);
      rd_chk("exc_vs_exrt_cause", CR_CAUSE, 32'h21);
      rd_chk("exc_vs_exrt_epc", CR_EPC, 32'h240);

      // Load-use hazard and fetch-busy stalls
      @(negedge clk);
      ld_hazard = 1'b1;
      #1;
      chk("ldh_stall", {28'd0, stall}, 32'h1);
      chk("ldh_flush", {28'd0, flush}, 32'h2);
      ld_hazard = 1'b0;
      if_busy = 1'b1;
      #1;
      chk("if_busy_stall", {28'd0, stall}, 32'hF);
      chk("if_busy_flush", {28'd0, flush}, 32'h0);
      if_busy = 1'b0;

      // Reset while an exception is being presented
      rst = 1'b1;
      present(2'(NOP), 5'd0, 3'd6, 32'd0, 30'hA0);
      tick();
      rst = 1'b0;
      rd_chk("rst2_lvl", CR_STK_LVL, 32'd0);
      rd_chk("rst2_epc", CR_EPC, 32'd0);
      rd_chk("rst2_cause", CR_CAUSE, 32'd0);
      rd_chk("rst2_exp_vector", CR_EXP_VECTOR, 32'd0);
      rd_chk("rst2_mask", CR_INT_MASK, 32'hFF);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
